// File: rtl/dnn_frame_sched_if.sv
// Frame scheduler bus: feature-extractor handshake, feature-RAM read port,
// normalizer data-valid pair, DNN engine start/busy and status/error flags.
`timescale 1ns/1ps
interface dnn_frame_sched_if;
    logic       frm_req_i;
    logic       frm_ack_o;
    logic       mfcc_rd_o;
    logic [3:0] mfcc_addr_o;
    logic       norm_dv_o;
    logic       norm_dv_i;
    logic       dnn_busy_i;
    logic       dnn_start_o;
    logic       busy_o;
    logic [2:0] fill_o;
    logic       err_clr_i;
    logic       err_tmo_o;
    logic       err_len_o;

    // Scheduler side
    modport slave (
        input  frm_req_i, norm_dv_i, dnn_busy_i, err_clr_i,
        output frm_ack_o, mfcc_rd_o, mfcc_addr_o, norm_dv_o, dnn_start_o, busy_o, fill_o,
               err_tmo_o, err_len_o
    );

    // Environment side (extractor, normalizer, DNN engine, host)
    modport master (
        output frm_req_i, norm_dv_i, dnn_busy_i, err_clr_i,
        input  frm_ack_o, mfcc_rd_o, mfcc_addr_o, norm_dv_o, dnn_start_o, busy_o, fill_o,
               err_tmo_o, err_len_o
    );
endinterface

// File: rtl/dnn_frame_sched.sv
// DNN frame scheduler: takes one MFCC frame from the extractor, streams its
// coefficients through the normalizer, counts the normalized context window
// coming back and kicks the DNN engine once the window is full.
`timescale 1ns/1ps
module dnn_frame_sched #(
    parameter int unsigned IDIM    = 12,
    parameter int unsigned INFRAME = 5,
    parameter int unsigned TMO     = 255
) (
    input logic              clk,
    input logic              rst_n,
    dnn_frame_sched_if.slave bus
);
    localparam int unsigned Words = INFRAME * IDIM;
    localparam int unsigned WcW   = ($clog2(Words + 1) > 7) ? $clog2(Words + 1) : 7;
    localparam int unsigned TmoW  = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StFetch    = 3'd1,
        StGap      = 3'd2,
        StWaitNorm = 3'd3,
        StStart    = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      addr_q, addr_d;
    logic [WcW-1:0]  wc_q, wc_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [2:0]      fill_q, fill_d;
    logic            ndv_q;
    logic            err_tmo_q, err_tmo_d;
    logic            err_len_q, err_len_d;
    logic            ack, rd, start, tmo_evt;

    // State, counters, delayed read strobe and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wc_q      <= '0;
            tmo_q     <= '0;
            fill_q    <= '0;
            ndv_q     <= 1'b0;
            err_tmo_q <= 1'b0;
            err_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wc_q      <= wc_d;
            tmo_q     <= tmo_d;
            fill_q    <= fill_d;
            ndv_q     <= rd;
            err_tmo_q <= err_tmo_d;
            err_len_q <= err_len_d;
        end
    end

    // Next-state, counter updates and strobe decode
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wc_d    = wc_q;
        tmo_d   = tmo_q;
        fill_d  = fill_q;
        ack     = 1'b0;
        rd      = 1'b0;
        start   = 1'b0;
        tmo_evt = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.frm_req_i) begin
                    ack     = 1'b1;
                    addr_d  = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                rd     = 1'b1;
                addr_d = addr_q + 4'd1;
                if (addr_q == 4'(IDIM - 1)) state_d = StGap;
            end
            StGap: begin
                // Final delayed norm_dv_o goes out here
                wc_d    = '0;
                tmo_d   = '0;
                state_d = StWaitNorm;
            end
            StWaitNorm: begin
                if (bus.norm_dv_i) begin
                    wc_d  = wc_q + 1'b1;
                    tmo_d = '0;
                    if (wc_q == WcW'(Words - 1)) begin
                        if (fill_q != 3'(INFRAME)) fill_d = fill_q + 3'd1;
                        state_d = StStart;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q == TmoW'(TMO - 1)) begin
                        tmo_evt = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StStart: begin
                if (fill_q == 3'(INFRAME)) begin
                    if (!bus.dnn_busy_i) begin
                        start   = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    // Window still warming up: no inference yet
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sticky errors: a new event in the clear cycle keeps the flag set
    always_comb begin
        err_tmo_d = tmo_evt | (err_tmo_q & ~bus.err_clr_i);
        err_len_d = (bus.norm_dv_i & (state_q != StWaitNorm)) | (err_len_q & ~bus.err_clr_i);
    end

    // Ack is combinational on frm_req_i; hold it low while reset is asserted
    assign bus.frm_ack_o   = ack & rst_n;
    assign bus.mfcc_rd_o   = rd;
    assign bus.mfcc_addr_o = rd ? addr_q : 4'd0;
    assign bus.norm_dv_o   = ndv_q;
    assign bus.dnn_start_o = start;
    assign bus.busy_o      = (state_q != StIdle);
    assign bus.fill_o      = fill_q;
    assign bus.err_tmo_o   = err_tmo_q;
    assign bus.err_len_o   = err_len_q;
endmodule

// File: tb/tb_dnn_frame_sched.sv
// Bench for dnn_frame_sched: drives extractor, normalizer and DNN engine,
// predicts window fill, start pulses, timing and error flags from a frame-level model.
`timescale 1ns/1ps
module tb_dnn_frame_sched;
    localparam int unsigned IDIM    = 12;
    localparam int unsigned INFRAME = 5;
    localparam int unsigned TMO     = 255;
    localparam int unsigned Words   = INFRAME * IDIM;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    dnn_frame_sched_if bus ();

    dnn_frame_sched #(.IDIM(IDIM), .INFRAME(INFRAME), .TMO(TMO)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Event monitor, sampled mid-cycle
    int unsigned cyc = 0;
    int unsigned ack_cnt = 0, start_cnt = 0, overlap_cnt = 0, start_cyc = 0;
    logic [3:0]  rd_addr_q[$];
    int unsigned rd_cyc_q[$];
    int unsigned ndv_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.frm_ack_o) ack_cnt++;
        if (bus.dnn_start_o) begin start_cnt++; start_cyc = cyc; end
        if (bus.frm_ack_o && bus.dnn_start_o) overlap_cnt++;
        if (bus.mfcc_rd_o) begin rd_addr_q.push_back(bus.mfcc_addr_o); rd_cyc_q.push_back(cyc); end
        if (bus.norm_dv_o) ndv_cyc_q.push_back(cyc);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [13:0] outs();
        return {bus.frm_ack_o, bus.mfcc_rd_o, bus.mfcc_addr_o, bus.norm_dv_o, bus.dnn_start_o,
                bus.busy_o, bus.fill_o, bus.err_tmo_o, bus.err_len_o};
    endfunction

    // Plays one frame: request, normalizer returns `words` words, optional busy engine.
    // Entered and left at 1ns after a rising edge.
    task automatic do_frame(input int unsigned words, input bit rand_gaps,
                            input int unsigned busy_len, output bit ok,
                            output int unsigned ack_c, output int unsigned last_c,
                            output int unsigned idle_c, output int unsigned hold_bad);
        bit got, gap_seen, back;
        ok = 1'b0; ack_c = 0; last_c = 0; idle_c = 0; hold_bad = 0;
        got = 1'b0; gap_seen = 1'b0; back = 1'b0;
        bus.frm_req_i = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (bus.frm_ack_o) begin got = 1'b1; ack_c = cyc; end
            @(posedge clk); #1;
        end
        bus.frm_req_i = 1'b0;
        if (!got) return;
        // GAP is the only cycle with norm_dv_o high and no read strobe
        for (int i = 0; i < 40 && !gap_seen; i++) begin
            @(negedge clk);
            if (bus.norm_dv_o && !bus.mfcc_rd_o) gap_seen = 1'b1;
            @(posedge clk); #1;
        end
        if (!gap_seen) return;
        for (int unsigned w = 0; w < words; w++) begin
            if (rand_gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            bus.norm_dv_i = 1'b1;
            last_c = cyc;
            if (w == words - 1 && busy_len != 0 && words == Words) bus.dnn_busy_i = 1'b1;
            @(posedge clk); #1;
            bus.norm_dv_i = 1'b0;
        end
        if (busy_len != 0 && words == Words) begin
            bus.frm_req_i = 1'b1;
            repeat (busy_len) begin
                @(negedge clk);
                if (bus.dnn_start_o || bus.frm_ack_o || !bus.busy_o) hold_bad++;
                @(posedge clk); #1;
            end
            bus.dnn_busy_i = 1'b0;
            bus.frm_req_i  = 1'b0;
        end
        for (int i = 0; i < 600 && !back; i++) begin
            @(negedge clk);
            if (!bus.busy_o) begin back = 1'b1; idle_c = cyc; end
            @(posedge clk); #1;
        end
        ok = back;
    endtask

    task automatic test_reset();
        bus.frm_req_i = 1'b1; bus.norm_dv_i = 1'b1; bus.dnn_busy_i = 1'b0; bus.err_clr_i = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (outs() !== 14'd0) begin
            n_err++; $display("FAIL reset_outputs: got %b want 0", outs());
        end
        bus.frm_req_i = 1'b0; bus.norm_dv_i = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (outs() !== 14'd0) begin
            n_err++; $display("FAIL reset_release_outputs: got %b want 0", outs());
        end
    endtask

    task automatic test_first_frame();
        bit ok; int unsigned a, l, d, hb, c0, s0, rb, nb;
        c0 = cyc; s0 = start_cnt; rb = rd_addr_q.size(); nb = ndv_cyc_q.size();
        do_frame(Words, 1'b0, 0, ok, a, l, d, hb);
        n_vec++; if (!ok) begin n_err++; $display("FAIL first_done: got 0 want 1"); end
        n_vec++; if (a !== c0) begin n_err++; $display("FAIL first_ack_cycle: got %0d want %0d", a, c0); end
        n_vec++;
        if (rd_addr_q.size() - rb !== IDIM) begin
            n_err++; $display("FAIL first_rd_count: got %0d want %0d", rd_addr_q.size() - rb, IDIM);
        end
        n_vec++;
        if (ndv_cyc_q.size() - nb !== IDIM) begin
            n_err++; $display("FAIL first_ndv_count: got %0d want %0d", ndv_cyc_q.size() - nb, IDIM);
        end
        for (int i = 0; i < int'(IDIM) && rb + i < rd_addr_q.size() && nb + i < ndv_cyc_q.size(); i++) begin
            n_vec++;
            if (rd_addr_q[rb+i] !== 4'(i) || rd_cyc_q[rb+i] !== a + 1 + i) begin
                n_err++;
                $display("FAIL first_rd[%0d]: got addr %0d cyc %0d want addr %0d cyc %0d",
                         i, rd_addr_q[rb+i], rd_cyc_q[rb+i], i, a + 1 + i);
            end
            n_vec++;
            if (ndv_cyc_q[nb+i] !== a + 2 + i) begin
                n_err++; $display("FAIL first_ndv[%0d]: got cyc %0d want %0d", i, ndv_cyc_q[nb+i], a + 2 + i);
            end
        end
        n_vec++; if (bus.fill_o !== 3'd1) begin n_err++; $display("FAIL first_fill: got %0d want 1", bus.fill_o); end
        n_vec++; if (start_cnt - s0 !== 0) begin n_err++; $display("FAIL first_no_start: got %0d want 0", start_cnt - s0); end
        n_vec++;
        if (d - a !== IDIM + 2 + Words + 1) begin
            n_err++; $display("FAIL first_spacing: got %0d want %0d", d - a, IDIM + 2 + Words + 1);
        end
    endtask

    task automatic test_timeout();
        bit ok; int unsigned a, l, d, hb, s0;
        s0 = start_cnt;
        do_frame(30, 1'b0, 0, ok, a, l, d, hb);
        n_vec++; if (!ok) begin n_err++; $display("FAIL tmo_done: got 0 want 1"); end
        n_vec++; if (bus.err_tmo_o !== 1'b1) begin n_err++; $display("FAIL tmo_flag: got %b want 1", bus.err_tmo_o); end
        n_vec++; if (d - l !== TMO + 1) begin n_err++; $display("FAIL tmo_delay: got %0d want %0d", d - l, TMO + 1); end
        n_vec++; if (bus.fill_o !== 3'd1) begin n_err++; $display("FAIL tmo_fill: got %0d want 1", bus.fill_o); end
        n_vec++; if (start_cnt - s0 !== 0) begin n_err++; $display("FAIL tmo_no_start: got %0d want 0", start_cnt - s0); end
        bus.err_clr_i = 1'b1; @(posedge clk); #1; bus.err_clr_i = 1'b0;
        n_vec++; if (bus.err_tmo_o !== 1'b0) begin n_err++; $display("FAIL tmo_clear: got %b want 0", bus.err_tmo_o); end
    endtask

    task automatic test_window_fill();
        bit ok; int unsigned a, l, d, hb, s0, fill_m, exp_s;
        fill_m = 1;
        for (int k = 2; k <= 6; k++) begin
            s0 = start_cnt;
            do_frame(Words, 1'b1, 0, ok, a, l, d, hb);
            if (fill_m < INFRAME) fill_m++;
            exp_s = (fill_m == INFRAME) ? 1 : 0;
            n_vec++; if (!ok) begin n_err++; $display("FAIL win%0d_done: got 0 want 1", k); end
            n_vec++;
            if (bus.fill_o !== 3'(fill_m)) begin
                n_err++; $display("FAIL win%0d_fill: got %0d want %0d", k, bus.fill_o, fill_m);
            end
            n_vec++;
            if (start_cnt - s0 !== exp_s) begin
                n_err++; $display("FAIL win%0d_starts: got %0d want %0d", k, start_cnt - s0, exp_s);
            end
            if (exp_s == 1) begin
                n_vec++;
                if (start_cyc !== l + 1) begin
                    n_err++; $display("FAIL win%0d_start_cyc: got %0d want %0d", k, start_cyc, l + 1);
                end
            end
        end
    endtask

    task automatic test_busy_hold();
        bit ok; int unsigned a, l, d, hb, s0, a0;
        s0 = start_cnt; a0 = ack_cnt;
        do_frame(Words, 1'b0, 20, ok, a, l, d, hb);
        n_vec++; if (!ok) begin n_err++; $display("FAIL busy_done: got 0 want 1"); end
        n_vec++; if (hb !== 0) begin n_err++; $display("FAIL busy_hold: got %0d bad cycles want 0", hb); end
        n_vec++; if (start_cnt - s0 !== 1) begin n_err++; $display("FAIL busy_starts: got %0d want 1", start_cnt - s0); end
        n_vec++; if (start_cyc !== l + 21) begin n_err++; $display("FAIL busy_start_cyc: got %0d want %0d", start_cyc, l + 21); end
        n_vec++; if (ack_cnt - a0 !== 1) begin n_err++; $display("FAIL busy_acks: got %0d want 1", ack_cnt - a0); end
        n_vec++; if (bus.fill_o !== 3'd5) begin n_err++; $display("FAIL busy_fill: got %0d want 5", bus.fill_o); end
    endtask

    task automatic test_len_err();
        bit err_m, dv, clr;
        bus.norm_dv_i = 1'b1; @(posedge clk); #1; bus.norm_dv_i = 1'b0;
        n_vec++; if (bus.err_len_o !== 1'b1) begin n_err++; $display("FAIL len_set: got %b want 1", bus.err_len_o); end
        n_vec++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL len_busy: got %b want 0", bus.busy_o); end
        bus.norm_dv_i = 1'b1; bus.err_clr_i = 1'b1; @(posedge clk); #1;
        bus.norm_dv_i = 1'b0; bus.err_clr_i = 1'b0;
        n_vec++; if (bus.err_len_o !== 1'b1) begin n_err++; $display("FAIL len_set_wins: got %b want 1", bus.err_len_o); end
        bus.err_clr_i = 1'b1; @(posedge clk); #1; bus.err_clr_i = 1'b0;
        n_vec++; if (bus.err_len_o !== 1'b0) begin n_err++; $display("FAIL len_clear: got %b want 0", bus.err_len_o); end
        err_m = 1'b0;
        for (int i = 0; i < 24; i++) begin
            dv = 1'($urandom_range(0, 1)); clr = 1'($urandom_range(0, 1));
            bus.norm_dv_i = dv; bus.err_clr_i = clr;
            @(posedge clk); #1;
            err_m = dv | (err_m & ~clr);
            n_vec++;
            if ({bus.err_len_o, bus.busy_o, bus.err_tmo_o} !== {err_m, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL len_rand[%0d]: got len/busy/tmo %b%b%b want %b00", i,
                         bus.err_len_o, bus.busy_o, bus.err_tmo_o, err_m);
            end
        end
        bus.norm_dv_i = 1'b0; bus.err_clr_i = 1'b0;
    endtask

    task automatic test_async_reset();
        bit hit, ok; int unsigned a, l, d, hb, a0, s0, c0;
        bus.norm_dv_i = 1'b1; @(posedge clk); #1; bus.norm_dv_i = 1'b0;
        bus.frm_req_i = 1'b1; hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (bus.mfcc_rd_o && bus.mfcc_addr_o == 4'd6) hit = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_vec++; if (!hit) begin n_err++; $display("FAIL arst_reach_addr6: got 0 want 1"); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (outs() !== 14'd0) begin n_err++; $display("FAIL arst_outputs: got %b want 0", outs()); end
        bus.frm_req_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        a0 = ack_cnt; s0 = start_cnt;
        repeat (30) @(posedge clk);
        #1;
        n_vec++; if (ack_cnt - a0 !== 0) begin n_err++; $display("FAIL arst_no_ack: got %0d want 0", ack_cnt - a0); end
        n_vec++; if (start_cnt - s0 !== 0) begin n_err++; $display("FAIL arst_no_start: got %0d want 0", start_cnt - s0); end
        n_vec++;
        if ({bus.busy_o, bus.fill_o, bus.err_len_o} !== 5'd0) begin
            n_err++; $display("FAIL arst_idle: got busy/fill/len %b/%0d/%b want 0/0/0",
                              bus.busy_o, bus.fill_o, bus.err_len_o);
        end
        c0 = cyc;
        do_frame(Words, 1'b0, 0, ok, a, l, d, hb);
        n_vec++; if (!ok || a !== c0) begin n_err++; $display("FAIL arst_new_ack: got cyc %0d want %0d", a, c0); end
        n_vec++; if (bus.fill_o !== 3'd1) begin n_err++; $display("FAIL arst_warmup_fill: got %0d want 1", bus.fill_o); end
        n_vec++; if (start_cnt - s0 !== 0) begin n_err++; $display("FAIL arst_warmup_start: got %0d want 0", start_cnt - s0); end
    endtask

    task automatic test_random();
        bit ok, full; int unsigned a, l, d, hb, s0, words, nf, blen, exp_s, fill_m;
        fill_m = 1;
        for (int f = 0; f < 10; f++) begin
            words  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, Words - 1) : Words;
            full   = (words == Words);
            nf     = (full && fill_m < INFRAME) ? fill_m + 1 : fill_m;
            exp_s  = (full && nf == INFRAME) ? 1 : 0;
            blen   = (exp_s == 1) ? $urandom_range(0, 6) : 0;
            s0 = start_cnt;
            do_frame(words, 1'b1, blen, ok, a, l, d, hb);
            n_vec++; if (!ok) begin n_err++; $display("FAIL rnd%0d_done: got 0 want 1", f); end
            n_vec++;
            if (bus.fill_o !== 3'(nf)) begin n_err++; $display("FAIL rnd%0d_fill: got %0d want %0d", f, bus.fill_o, nf); end
            n_vec++;
            if (start_cnt - s0 !== exp_s) begin
                n_err++; $display("FAIL rnd%0d_starts: got %0d want %0d", f, start_cnt - s0, exp_s);
            end
            n_vec++;
            if ({bus.err_tmo_o, bus.err_len_o} !== {~full, 1'b0}) begin
                n_err++; $display("FAIL rnd%0d_errs: got tmo/len %b%b want %b0", f,
                                  bus.err_tmo_o, bus.err_len_o, ~full);
            end
            n_vec++; if (hb !== 0) begin n_err++; $display("FAIL rnd%0d_hold: got %0d want 0", f, hb); end
            if (!full) begin
                n_vec++;
                if (d - l !== TMO + 1) begin n_err++; $display("FAIL rnd%0d_tmo_delay: got %0d want %0d", f, d - l, TMO + 1); end
                bus.err_clr_i = 1'b1; @(posedge clk); #1; bus.err_clr_i = 1'b0;
            end else if (exp_s == 1) begin
                n_vec++;
                if (start_cyc !== l + 1 + blen) begin
                    n_err++; $display("FAIL rnd%0d_start_cyc: got %0d want %0d", f, start_cyc, l + 1 + blen);
                end
            end
            fill_m = nf;
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_timeout();
        test_window_fill();
        test_busy_hold();
        test_len_err();
        test_async_reset();
        test_random();
        n_vec++;
        if (overlap_cnt !== 0) begin n_err++; $display("FAIL ack_start_overlap: got %0d want 0", overlap_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dnn_frame_sched.md
DNN_FRAME_SCHED -- requirements
Module: dnn_frame_sched

Interface
REQ-001 The module SHALL have the following parameters:
- IDIM, 12, coefficients per MFCC frame.
- INFRAME, 5, context-window frames.
- TMO, 255, WAIT_NORM timeout in cycles.
REQ-002 The module SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- frm_req_i, in, 1, level: feature extractor holds one MFCC frame ready.
- frm_ack_o, out, 1, one-cycle pulse: frame taken, extractor drops request.
- mfcc_rd_o, out, 1, read strobe to feature RAM (read latency 1 cycle).
- mfcc_addr_o, out, 4, coefficient address 0..IDIM-1.
- norm_dv_o, out, 1, data-valid to normalizer dv_i.
- norm_dv_i, in, 1, normalizer dv_o.
- dnn_busy_i, in, 1, DNN layer engine busy.
- dnn_start_o, out, 1, one-cycle start pulse to DNN engine.
- busy_o, out, 1, high whenever state != IDLE.
- fill_o, out, 3, valid frames in window, saturating at INFRAME.
- err_clr_i, in, 1, synchronous clear of sticky errors.
- err_tmo_o, out, 1, sticky: normalizer output burst timed out.
- err_len_o, out, 1, sticky: norm_dv_i seen outside WAIT_NORM.

Function
REQ-003 The FSM SHALL have states IDLE, FETCH, GAP, WAIT_NORM, START, encoded in 3 bits.
REQ-004 In IDLE, when frm_req_i=1, the FSM SHALL pulse frm_ack_o for that cycle and enter FETCH with addr counter = 0.
REQ-005 In FETCH, mfcc_rd_o SHALL be 1 for exactly IDIM consecutive cycles with mfcc_addr_o = 0,1,...,IDIM-1; then the FSM enters GAP.
REQ-006 norm_dv_o SHALL equal mfcc_rd_o delayed by one register, giving IDIM contiguous high cycles preceded and followed by at least one low cycle.
REQ-007 GAP SHALL last exactly 1 cycle, covering the delayed final norm_dv_o; then the FSM enters WAIT_NORM with word counter = 0 and timeout counter = 0.
REQ-008 In WAIT_NORM, each cycle with norm_dv_i=1 SHALL increment the word counter (width >= 7 bits).
REQ-009 When the word counter reaches INFRAME*IDIM (60 by default), the FSM SHALL saturate-increment fill_o and enter START.
REQ-010 In WAIT_NORM, the timeout counter SHALL increment on cycles with norm_dv_i=0 and reset on norm_dv_i=1.
REQ-011 If the timeout counter reaches TMO, the FSM SHALL set err_tmo_o, leave fill_o unchanged and return to IDLE.
REQ-012 In START, if fill_o == INFRAME and dnn_busy_i=0, dnn_start_o SHALL pulse for one cycle and the FSM returns to IDLE.
REQ-013 In START, if fill_o == INFRAME and dnn_busy_i=1, the FSM SHALL hold in START with dnn_start_o=0.
REQ-014 In START, if fill_o < INFRAME (window warm-up), the FSM SHALL return to IDLE without pulsing dnn_start_o.
REQ-015 frm_req_i SHALL be ignored outside IDLE; a held request is accepted on the first IDLE cycle.
REQ-016 Minimum frame-to-frame spacing SHALL therefore be IDIM+2+words+1 cycles.
REQ-017 norm_dv_i=1 in any state other than WAIT_NORM SHALL set err_len_o; the FSM state SHALL be unaffected.
REQ-018 err_clr_i SHALL clear both error flags.
REQ-019 If err_clr_i and a new error event occur in the same cycle, the error flag SHALL be set (set wins).
REQ-020 frm_ack_o and dnn_start_o SHALL never be high in the same cycle.

Reset
REQ-021 rst_n low SHALL asynchronously force state = IDLE and all counters = 0.
REQ-022 rst_n low SHALL force fill_o=0 and all outputs 0, including err_tmo_o and err_len_o.
REQ-023 Reset asserted mid-FETCH or mid-WAIT_NORM SHALL abort the operation with no pulses emitted after deassertion.
REQ-024 After reset release, the first accepted frame SHALL begin the warm-up (fill_o from 0).

Verification
REQ-025 Scenario 1: rst_n released; frm_req_i held high; normalizer model returns 60 words. Required: ack at first IDLE cycle; 12 rd strobes at addr 0..11; norm_dv_o high 12 cycles lagging by 1; fill_o=1; no dnn_start_o.
REQ-026 Scenario 2: five consecutive frames. Required: dnn_start_o pulses exactly once, in the 5th START; fill_o stays 5 after a 6th frame, which also pulses start.
REQ-027 Scenario 3: dnn_busy_i=1 for 20 cycles at START with fill_o=5. Required: FSM holds START; dnn_start_o pulses in the cycle after dnn_busy_i falls; frm_req_i not acked meanwhile.
REQ-028 Scenario 4: normalizer returns only 30 words then stays silent. Required: err_tmo_o set 255 cycles after the last word; return to IDLE; fill_o unchanged.
REQ-029 Scenario 5: norm_dv_i pulsed in IDLE. Required: err_len_o=1, busy_o=0. Then err_clr_i pulsed together with another norm_dv_i. Required: err_len_o stays 1.
REQ-030 Scenario 6: rst_n low asynchronously at FETCH addr 6. Required: all outputs 0 immediately; no ack or start after release until a new frm_req_i.
